// File: rtl/l2_request_arbiter.sv
// Arbitrates the single L2 block-read port between the instruction and data caches,
// one outstanding transaction at a time. Define ROUND_ROBIN_EN for alternating tie-breaks.
module l2_request_arbiter #(
    parameter int BLOCK_ADDRESS_WIDTH = 26,
    parameter int BLOCK_WIDTH         = 512
) (
    input  logic                           CLK,
    input  logic                           RST,

    input  logic                           ADDRESS_TO_L2_VALID_INS,
    output logic                           ADDRESS_TO_L2_READY_INS,
    input  logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INS,
    output logic                           DATA_FROM_L2_VALID_INS,
    input  logic                           DATA_FROM_L2_READY_INS,
    output logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INS,

    input  logic                           ADDRESS_TO_L2_VALID_DAT,
    output logic                           ADDRESS_TO_L2_READY_DAT,
    input  logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_DAT,
    output logic                           DATA_FROM_L2_VALID_DAT,
    input  logic                           DATA_FROM_L2_READY_DAT,
    output logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_DAT,

    output logic                           ADDRESS_TO_L2_VALID,
    input  logic                           ADDRESS_TO_L2_READY,
    output logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2,
    input  logic                           DATA_FROM_L2_VALID,
    output logic                           DATA_FROM_L2_READY,
    input  logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic SEL_INS = 1'b0;
    localparam logic SEL_DAT = 1'b1;

    logic [1:0]                     state_q, state_d;
    logic                           owner_q, owner_d;
    logic [BLOCK_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                           last_grant_q, last_grant_d;

    logic any_req;
    logic tie;
    logic tie_pick;
    logic winner;
    logic owner_ready;
    logic in_idle;
    logic in_req;
    logic in_resp;

    assign any_req = ADDRESS_TO_L2_VALID_INS | ADDRESS_TO_L2_VALID_DAT;
    assign tie     = ADDRESS_TO_L2_VALID_INS & ADDRESS_TO_L2_VALID_DAT;

`ifdef ROUND_ROBIN_EN
    // Tie goes to whoever was not served last; reset value DAT makes the first tie go to INS.
    assign tie_pick = ~last_grant_q;
`else
    assign tie_pick = SEL_DAT;
`endif

    assign winner = tie ? tie_pick : (ADDRESS_TO_L2_VALID_DAT ? SEL_DAT : SEL_INS);

    assign owner_ready = (owner_q == SEL_DAT) ? DATA_FROM_L2_READY_DAT : DATA_FROM_L2_READY_INS;

    // Control outputs are held at their reset values while RST is high, whatever the state.
    assign in_idle = (state_q == ST_IDLE) & ~RST;
    assign in_req  = (state_q == ST_REQ)  & ~RST;
    assign in_resp = (state_q == ST_RESP) & ~RST;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_REQ;
                    owner_d      = winner;
                    last_grant_d = winner;
                    addr_d       = (winner == SEL_DAT) ? ADDRESS_TO_L2_DAT : ADDRESS_TO_L2_INS;
                end
            end
            ST_REQ: begin
                if (ADDRESS_TO_L2_READY) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (DATA_FROM_L2_VALID && owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= SEL_INS;
            addr_q       <= '0;
            last_grant_q <= SEL_DAT;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ADDRESS_TO_L2_READY_INS = in_idle & ADDRESS_TO_L2_VALID_INS & (winner == SEL_INS);
    assign ADDRESS_TO_L2_READY_DAT = in_idle & ADDRESS_TO_L2_VALID_DAT & (winner == SEL_DAT);

    assign ADDRESS_TO_L2_VALID = in_req;
    assign ADDRESS_TO_L2       = addr_q;

    // L2 data is only consumed while a granted transaction awaits its block.
    assign DATA_FROM_L2_READY     = in_resp & owner_ready;
    assign DATA_FROM_L2_VALID_INS = in_resp & (owner_q == SEL_INS) & DATA_FROM_L2_VALID;
    assign DATA_FROM_L2_VALID_DAT = in_resp & (owner_q == SEL_DAT) & DATA_FROM_L2_VALID;

    assign DATA_FROM_L2_INS = DATA_FROM_L2;
    assign DATA_FROM_L2_DAT = DATA_FROM_L2;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized bench for l2_request_arbiter against a transaction-level reference model.
module tb_l2_request_arbiter;

    localparam int AW = 26;
    localparam int BW = 512;
    localparam int NUM_CYCLES = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          vi, vd, rdy_i, rdy_d, dvi, dvd, dri, drd;
    logic [AW-1:0] ai, ad, l2_addr;
    logic [BW-1:0] data_i, data_d, l2_data;
    logic          l2_av, l2_ar, l2_dv, l2_dr;

    always #5 clk = ~clk;

    l2_request_arbiter #(.BLOCK_ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .CLK                     (clk),
        .RST                     (rst),
        .ADDRESS_TO_L2_VALID_INS (vi),
        .ADDRESS_TO_L2_READY_INS (rdy_i),
        .ADDRESS_TO_L2_INS       (ai),
        .DATA_FROM_L2_VALID_INS  (dvi),
        .DATA_FROM_L2_READY_INS  (dri),
        .DATA_FROM_L2_INS        (data_i),
        .ADDRESS_TO_L2_VALID_DAT (vd),
        .ADDRESS_TO_L2_READY_DAT (rdy_d),
        .ADDRESS_TO_L2_DAT       (ad),
        .DATA_FROM_L2_VALID_DAT  (dvd),
        .DATA_FROM_L2_READY_DAT  (drd),
        .DATA_FROM_L2_DAT        (data_d),
        .ADDRESS_TO_L2_VALID     (l2_av),
        .ADDRESS_TO_L2_READY     (l2_ar),
        .ADDRESS_TO_L2           (l2_addr),
        .DATA_FROM_L2_VALID      (l2_dv),
        .DATA_FROM_L2_READY      (l2_dr),
        .DATA_FROM_L2            (l2_data)
    );

    int num_checks = 0;
    int num_errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] observed, input logic [BW-1:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int w = 0; w < BW / 32; w++) begin
            b[w*32 +: 32] = $urandom;
        end
        return b;
    endfunction

    // Reference model: one outstanding transaction described by who owns it,
    // which address it carries and whether L2 has taken the address yet.
    bit          m_busy;
    bit          m_sent;
    bit          m_owner;     // 0 = instruction cache, 1 = data cache
    bit          m_last;
    logic [AW-1:0] m_addr;
    int          served_ins, served_dat, txn_count;

    function automatic bit pick_winner(input bit req_i, input bit req_d, input bit last);
`ifdef ROUND_ROBIN_EN
        if (req_i && req_d) return !last;
`endif
        return req_d;
    endfunction

    initial begin
        bit   win;
        logic e_rdy_i, e_rdy_d, e_av, e_dr, e_vi, e_vd;

        m_busy = 0; m_sent = 0; m_owner = 0; m_last = 1; m_addr = '0;
        served_ins = 0; served_dat = 0; txn_count = 0;
        rst = 1'b1;
        vi = 0; vd = 0; ai = '0; ad = '0; dri = 0; drd = 0;
        l2_ar = 0; l2_dv = 0; l2_data = '0;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            rst     = (cyc < 3) ? 1'b1 : ($urandom_range(0, 99) == 0);
            vi      = ($urandom_range(0, 99) < 55);
            vd      = ($urandom_range(0, 99) < 55);
            ai      = AW'($urandom);
            ad      = AW'($urandom);
            dri     = ($urandom_range(0, 99) < 60);
            drd     = ($urandom_range(0, 99) < 60);
            l2_ar   = ($urandom_range(0, 99) < 45);
            l2_dv   = ($urandom_range(0, 99) < 50);
            l2_data = rand_block();
            #1;

            win     = pick_winner(vi, vd, m_last);
            e_rdy_i = 0; e_rdy_d = 0; e_av = 0; e_dr = 0; e_vi = 0; e_vd = 0;
            if (!rst) begin
                if (!m_busy) begin
                    e_rdy_i = vi && !win;
                    e_rdy_d = vd && win;
                end else if (!m_sent) begin
                    e_av = 1;
                end else begin
                    e_dr = m_owner ? drd : dri;
                    if (m_owner) e_vd = l2_dv;
                    else         e_vi = l2_dv;
                end
            end

            check("ready_ins", rdy_i, e_rdy_i);
            check("ready_dat", rdy_d, e_rdy_d);
            check("l2_addr_valid", l2_av, e_av);
            check("l2_addr", l2_addr, m_addr);
            check("l2_data_ready", l2_dr, e_dr);
            check("valid_ins", dvi, e_vi);
            check("valid_dat", dvd, e_vd);
            if (e_vi) check("block_ins", data_i, l2_data);
            if (e_vd) check("block_dat", data_d, l2_data);

            if (rst) begin
                m_busy = 0; m_sent = 0; m_owner = 0; m_last = 1; m_addr = '0;
            end else if (!m_busy) begin
                if (vi || vd) begin
                    m_busy  = 1;
                    m_sent  = 0;
                    m_owner = win;
                    m_last  = win;
                    m_addr  = win ? ad : ai;
                end
            end else if (!m_sent) begin
                if (l2_ar) m_sent = 1;
            end else if (l2_dv && (m_owner ? drd : dri)) begin
                m_busy = 0;
                txn_count++;
                if (m_owner) served_dat++;
                else         served_ins++;
                $display("txn %0d: %s block for addr %0h delivered at %0t",
                         txn_count, m_owner ? "DAT" : "INS", m_addr, $time);
            end
        end

        check("served_ins_nonzero", 512'(served_ins > 0), 512'(1));
        check("served_dat_nonzero", 512'(served_dat > 0), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
